// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame
// UART transmitter with an internal baud divider, a valid/ready input
// handshake and a configurable frame: start bit, DATA_BITS data bits sent
// LSB first, an optional parity bit, then STOP_BITS stop bits.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity by default, odd when PARITY_ODD = 1). Without the
// macro there is no parity state and PARITY_ODD has no effect.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tx_valid     frame request; tx_data is valid while high
//   tx_data      payload, DATA_BITS wide, sent LSB first
//   tx_ready     high in IDLE; the block can accept a frame
//   tx_busy      high while a frame is on the line
//   tx_done      one-clock pulse during the final clock of the last stop bit
//   uart_tx      registered serial line, idles high
//   dbg_state_o  current FSM state (debug observation only)
//
// Handshake: a frame is accepted on the clock edge where tx_valid && tx_ready.
// tx_data is copied into the shift register on that edge. A tx_valid seen
// while tx_ready is low is dropped, not queued. The source keeps tx_valid
// high until it sees tx_ready.
module uart_tx_frame #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 uart_tx,
  output logic [2:0]           dbg_state_o
);

  // Bit period in clocks, rounded to the nearest integer.
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: bit period DIV must be at least 2 clocks");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The baud counter only runs inside a frame, so the start bit begins
    // on the clock right after acceptance with no phase jitter.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        if (tx_valid) begin
          shift_d = tx_data;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 4'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = 4'd0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == 4'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase

    // The line level is decoded from the next state so the registered
    // output changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx_ready    = (state_q == IDLE);
  assign tx_busy     = !tx_ready;
  assign tx_done     = (state_q == STOP) && bit_end && (idx_q == 4'(STOP_BITS - 1));
  assign uart_tx     = tx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_frame. Three instances share clk/rst_n:
//   dut0: defaults (8 data bits, 1 stop bit, even parity if compiled in)
//   dut1: DATA_BITS = 7, STOP_BITS = 2
//   dut2: defaults with PARITY_ODD = 1
// All outputs are sampled on the falling edge. "clock j" is the j-th falling
// edge after the rising edge that accepted the frame.
module tb_uart_tx_frame;

  localparam int DIV = 104;  // (12000000 + 57600) / 115200
`ifdef UART_TX_PARITY_EN
  localparam int NP = 1;
`else
  localparam int NP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
  logic [7:0] data0 = '0, data2 = '0;
  logic [6:0] data1 = '0;
  logic       ready0, busy0, done0, tx0;
  logic       ready1, busy1, done1, tx1;
  logic       ready2, busy2, done2, tx2;
  logic [2:0] state0, state1, state2;

  int checks = 0;
  int errors = 0;

  uart_tx_frame dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid0), .tx_data(data0),
    .tx_ready(ready0), .tx_busy(busy0), .tx_done(done0), .uart_tx(tx0),
    .dbg_state_o(state0)
  );

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid1), .tx_data(data1),
    .tx_ready(ready1), .tx_busy(busy1), .tx_done(done1), .uart_tx(tx1),
    .dbg_state_o(state1)
  );

  uart_tx_frame #(.PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid2), .tx_data(data2),
    .tx_ready(ready2), .tx_busy(busy2), .tx_done(done2), .uart_tx(tx2),
    .dbg_state_o(state2)
  );

  task automatic chk(input logic [8:0] obs, input logic [8:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_line(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_ready(input int s);
    case (s)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [8:0] d);
    case (s)
      0: begin valid0 = v; data0 = d[7:0]; end
      1: begin valid1 = v; data1 = d[6:0]; end
      default: begin valid2 = v; data2 = d[7:0]; end
    endcase
  endtask

  // Presents one frame; returns at clock 1 with tx_valid dropped.
  task automatic start_frame(input int s, input logic [8:0] d, input string tag);
    @(negedge clk);
    chk(get_ready(s), 1, {tag, " ready before accept"});
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, d);
  endtask

  // Called at clock 1 of a frame; returns at clock F (the tx_done clock).
  // Checks the first and last clock of every bit slot, tx_done on every slot
  // start and around the end, and tx_ready low throughout. poke_at > 0 drives
  // a new request (data 0xC3) for three clocks in the middle of the frame.
  task automatic check_frame(input int s, input logic [8:0] d, input int nd, input int ns,
                             input logic pbit, input int poke_at, input string tag);
    int f;
    f = (1 + nd + NP + ns) * DIV;
    for (int j = 1; j <= f; j++) begin
      int   slot;
      int   pos;
      logic e;
      slot = (j - 1) / DIV;
      pos  = (j - 1) % DIV;
      if (slot == 0)             e = 1'b0;
      else if (slot <= nd)       e = d[slot-1];
      else if (slot <= nd + NP)  e = pbit;
      else                       e = 1'b1;
      if (pos == 0 || pos == DIV - 1)
        chk(get_line(s), e, $sformatf("%s line clk %0d", tag, j));
      if (pos == 0 || j >= f - 1)
        chk(get_done(s), (j == f), $sformatf("%s done clk %0d", tag, j));
      if (pos == 0)
        chk(get_ready(s), 0, $sformatf("%s ready clk %0d", tag, j));
      if (poke_at > 0 && j == poke_at)     drive(s, 1'b1, 9'h0C3);
      if (poke_at > 0 && j == poke_at + 3) drive(s, 1'b0, 9'h0C3);
      if (j < f) @(negedge clk);
    end
  endtask

  // Clock F+1: back in IDLE with the line high.
  task automatic check_idle(input int s, input string tag);
    @(negedge clk);
    chk(get_line(s), 1, {tag, " idle line"});
    chk(get_ready(s), 1, {tag, " idle ready"});
    chk(get_busy(s), 0, {tag, " idle busy"});
    chk(get_done(s), 0, {tag, " idle done"});
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx0, 1, "reset line");
    chk(ready0, 1, "reset ready");
    chk(busy0, 0, "reset busy");
    chk(done0, 0, "reset done");
    chk(state0, 0, "reset state");
    chk(tx1, 1, "reset line dut1");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 (or 8E1) frame of 0xA5: bits 1,0,1,0,0,1,0,1; even parity 0
    start_frame(0, 9'h0A5, "a5");
    check_frame(0, 9'h0A5, 8, 1, 1'b0, 0, "a5");
    check_idle(0, "a5");

    // Odd-parity instance, same data: parity bit 1
    start_frame(2, 9'h0A5, "a5odd");
    check_frame(2, 9'h0A5, 8, 1, 1'b1, 0, "a5odd");
    check_idle(2, "a5odd");

    // 7 data bits, 2 stop bits, 0x55: bits 1,0,1,0,1,0,1; parity 0
    start_frame(1, 9'h055, "55s2");
    check_frame(1, 9'h055, 7, 2, 1'b0, 0, "55s2");
    check_idle(1, "55s2");

    // Back-to-back with tx_valid held: data changes to 0xFF after the first
    // acceptance, so the second frame carries 0xFF and starts F+1 clocks later.
    @(negedge clk);
    drive(0, 1'b1, 9'h000);
    @(negedge clk);
    drive(0, 1'b1, 9'h0FF);
    check_frame(0, 9'h000, 8, 1, 1'b0, 0, "b2b0");
    @(negedge clk);
    chk(tx0, 1, "b2b gap line");
    chk(ready0, 1, "b2b gap ready");
    @(negedge clk);
    drive(0, 1'b0, 9'h0FF);
    check_frame(0, 9'h0FF, 8, 1, 1'b0, 0, "b2b1");
    check_idle(0, "b2b1");

    // Request during a frame is ignored and data changes do not leak in
    start_frame(0, 9'h03C, "3c");
    check_frame(0, 9'h03C, 8, 1, 1'b0, 300, "3c");
    check_idle(0, "3c");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk(busy0, 0, $sformatf("3c no second frame %0d", k));
      chk(tx0, 1, $sformatf("3c line high %0d", k));
    end

    // Reset at clock 500 of a 0xA5 frame (data bit 3 = 0 on the line)
    start_frame(0, 9'h0A5, "rst");
    for (int j = 2; j <= 500; j++) @(negedge clk);
    chk(tx0, 0, "rst line before reset");
    rst_n = 1'b0;
    #1;
    chk(tx0, 1, "rst line async");
    chk(ready0, 1, "rst ready");
    chk(done0, 0, "rst done");
    chk(state0, 0, "rst state");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk(done0, 0, $sformatf("rst no done %0d", k));
      chk(tx0, 1, $sformatf("rst line idle %0d", k));
    end

    // Frame after reset: 0x81, parity 0
    start_frame(0, 9'h081, "81");
    check_frame(0, 9'h081, 8, 1, 1'b0, 0, "81");
    check_idle(0, "81");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with an internal baud-rate divider, valid/ready input handshake and configurable frame format: data bits, stop bits and optional parity. It drives the board UART TX pin from the 12 MHz system clock and is the next generation of the fixed 8N1 transmitter. The external bps_clk/bps_en pairing is gone, and the block accepts back-to-back frames from a FIFO or command sequencer.

## Interface
- CLK_FREQ, 12000000, system clock frequency in Hz
- BAUD, 115200, line rate in baud
- DATA_BITS, 8, data bits per frame; legal range 5..9
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- clk input 1 system clock
- rst_n input 1 asynchronous, active-low reset
- tx_valid input 1 frame request; tx_data is valid while this is high
- tx_data input DATA_BITS payload, sent LSB first
- tx_ready output 1 high when the block can accept a frame
- tx_busy output 1 high while a frame is on the line
- tx_done output 1 one-clock pulse at the end of the last stop bit
- uart_tx output 1 serial line; idles high

## Operation
- Bit period: DIV = (CLK_FREQ + BAUD/2) / BAUD clocks, rounded to nearest.
- Elaboration fails if DIV < 2 or if DATA_BITS or STOP_BITS is out of range.
- Baud counter width is clog2(DIV). The counter counts 0..DIV-1, and every bit lasts exactly DIV clocks.
- The counter is held at 0 in IDLE. There is no free-running phase, so start-bit jitter is 0.
- States:
  - IDLE: line high; tx_ready = 1.
  - START: line low, 1 bit.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: 1 bit; exists only when compiled in.
  - STOP: STOP_BITS bits, line high.
- Transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Each transition fires on the clock where the baud counter is DIV-1 and the bit index of the current state is exhausted.
- Handshake: a frame is accepted on the clock edge where tx_valid && tx_ready.
  - tx_data is captured into a shift register at that edge.
  - Later changes on tx_data have no effect on the frame in flight.
  - tx_valid while tx_ready = 0 is ignored, not queued.
  - The source holds tx_valid until it observes tx_ready.
- tx_ready = (state == IDLE). tx_busy = !tx_ready.
- Bit index counter: 4 bits, reset to 0 on each state entry. It never wraps beyond DATA_BITS-1 or STOP_BITS-1.
- uart_tx is a registered output and is glitch-free.

## Timing
- Reset values: uart_tx = 1, state = IDLE, tx_ready = 1, tx_busy = 0, tx_done = 0, baud counter = 0, shift register = 0.
- Reset mid-frame: on rst_n low, uart_tx goes high asynchronously and the frame is abandoned. No tx_done pulse is issued.
- Acceptance at edge N: uart_tx falls at edge N+1. tx_ready and tx_busy change at edge N+1.
- Start bit occupies clocks N+1 .. N+DIV. Data bit k starts at edge N+1+(k+1)·DIV.
- Frame length: F = (1 + DATA_BITS + P + STOP_BITS)·DIV clocks, where P = 1 if parity is compiled in, else 0.
- tx_done pulses high for the single clock ending the last stop bit, i.e. during the clock at edge N+F. IDLE is entered at edge N+F+1.
- Back-to-back frames: if tx_valid is held high, the next frame is accepted at edge N+F+1. There is one extra idle-high clock between frames.
- Simultaneous tx_done and new tx_valid: no acceptance, because tx_ready is still 0. The frame is taken on the following clock.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state is present, sent after the last data bit.
  - Even parity: the bit is the XOR of all DATA_BITS captured data bits.
  - Odd parity: the bit is the inverse of that XOR.
  - PARITY_ODD selects the sense.
- Undefined: no PARITY state and no parity logic. P = 0 and PARITY_ODD is ignored.

## Test plan
- Defaults, no macro, send 0xA5:
  - Line low for clocks 1..104 after acceptance.
  - Then bits 1,0,1,0,0,1,0,1, each 104 clocks, then high.
  - tx_done at clock 1040; tx_ready back at clock 1041.
- UART_TX_PARITY_EN, PARITY_ODD = 0, 0xA5: parity bit = 0 in bit slot 9. Same data with PARITY_ODD = 1: parity bit = 1. Frame length is 1144 clocks.
- STOP_BITS = 2, DATA_BITS = 7, 0x55: data bits 1,0,1,0,1,0,1, then 208 clocks high before tx_done. Total frame is 1040 clocks.
- tx_valid held high with data 0x00 then 0xFF:
  - Second start edge falls exactly F+1 clocks after the first.
  - Line is high for exactly 1 clock between frames.
- Change tx_data from 0x3C to 0xC3 and pulse tx_valid mid-frame: transmitted frame stays 0x3C, and no second frame is sent.
- Assert rst_n low at clock 500 of a frame:
  - uart_tx is immediately 1, tx_ready = 1, and no tx_done pulse occurs.
  - After release, a new 0x81 frame transmits correctly.
